// File: rtl/pipe_stage_skid_if.sv
// Handshake/payload bundle for one pipeline segment register.
// The stage itself connects through the slave modport; the driving environment uses master.
interface pipe_stage_skid_if #(
   parameter int unsigned DATA_W = 69,
   parameter int unsigned CTRL_W = 9
);
   logic              i_valid;
   logic              o_in_ready;
   logic [DATA_W-1:0] i_data;
   logic [CTRL_W-1:0] i_ctrl;
   logic              o_valid;
   logic              i_out_ready;
   logic [DATA_W-1:0] o_data;
   logic [CTRL_W-1:0] o_ctrl;

   modport slave (
      input  i_valid, i_data, i_ctrl, i_out_ready,
      output o_in_ready, o_valid, o_data, o_ctrl
   );

   modport master (
      output i_valid, i_data, i_ctrl, i_out_ready,
      input  o_in_ready, o_valid, o_data, o_ctrl
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline segment register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush, gated control field and a saturating stall counter.
module pipe_stage_skid #(
   parameter int unsigned          DATA_W   = 69,
   parameter int unsigned          CTRL_W   = 9,
   parameter logic [CTRL_W-1:0]    CTRL_RST = '0,
   parameter int unsigned          CNT_W    = 16
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_clk_en,
   input  logic                i_flush,
   input  logic                i_cnt_clr,
   pipe_stage_skid_if.slave    bus,
   output logic [1:0]          o_level,
   output logic [CNT_W-1:0]    o_stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              m_valid_q, m_valid_d;
   logic              s_valid_q, s_valid_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic [DATA_W-1:0] s_data_q,  s_data_d;
   logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
   logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic              in_fire,   out_fire;

   // Ready comes only from the skid slot, so it never depends on downstream ready
   assign bus.o_in_ready = !s_valid_q;
   assign bus.o_valid    = m_valid_q;
   assign bus.o_data     = m_data_q;
   assign bus.o_ctrl     = m_valid_q ? m_ctrl_q : CTRL_RST;
   assign o_level        = {1'b0, m_valid_q} + {1'b0, s_valid_q};
   assign o_stall_cnt    = cnt_q;

   assign in_fire  = bus.i_valid & !s_valid_q & i_clk_en;
   assign out_fire = m_valid_q & bus.i_out_ready & i_clk_en;

   always_comb begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      m_data_d  = m_data_q;
      s_data_d  = s_data_q;
      m_ctrl_d  = m_ctrl_q;
      s_ctrl_d  = s_ctrl_q;
      cnt_d     = cnt_q;

      if (i_flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
         m_ctrl_d  = CTRL_RST;
         s_ctrl_d  = CTRL_RST;
      end else if (i_clk_en) begin
         if (out_fire || !m_valid_q) begin
            if (s_valid_q) begin
               m_valid_d = 1'b1;
               m_data_d  = s_data_q;
               m_ctrl_d  = s_ctrl_q;
               s_valid_d = 1'b0;
            end else if (in_fire) begin
               m_valid_d = 1'b1;
               m_data_d  = bus.i_data;
               m_ctrl_d  = bus.i_ctrl;
            end else begin
               m_valid_d = 1'b0;
            end
         end else if (in_fire) begin
            // Main register is stuck downstream: park the new payload in the skid slot
            s_valid_d = 1'b1;
            s_data_d  = bus.i_data;
            s_ctrl_d  = bus.i_ctrl;
         end
      end

      if (i_cnt_clr) begin
         cnt_d = '0;
      end else if (i_clk_en && m_valid_q && !bus.i_out_ready && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         m_data_q  <= '0;
         s_data_q  <= '0;
         m_ctrl_q  <= CTRL_RST;
         s_ctrl_q  <= CTRL_RST;
         cnt_q     <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
         m_data_q  <= m_data_d;
         s_data_q  <= s_data_d;
         m_ctrl_q  <= m_ctrl_d;
         s_ctrl_q  <= s_ctrl_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register for the MIPS pipeline segment registers (IF/ID, ID/EX, EX/M, M/WB).
- Adds valid/ready handshaking, a 2-entry skid buffer for back-pressure, synchronous flush, control-field bubble gating and a saturating stall counter.
- Sits between two pipeline stages, replacing the fixed single-register segment blocks.
- Payload is split into a data field and a control field. The control field (mem_read, mem_write, reg_write, halt, ...) is forced to a safe value whenever the stage is empty or flushed.

Parameters:
- DATA_W, 69, width of the data field (e.g. alu_result + write_data + rd).
- CTRL_W, 9, width of the control field.
- CTRL_RST, {CTRL_W{1'b0}}, control value driven when empty, flushed or in reset.
- CNT_W, 16, width of the stall counter.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_clk_en  input  1  global stage enable (debug-unit step control).
- i_flush  input  1  synchronous kill of all stage contents.
- i_valid  input  1  upstream payload valid.
- o_in_ready  output  1  stage can accept a payload.
- i_data  input  DATA_W  upstream data field.
- i_ctrl  input  CTRL_W  upstream control field.
- o_valid  output  1  downstream payload valid.
- i_out_ready  input  1  downstream accepts payload.
- o_data  output  DATA_W  downstream data field.
- o_ctrl  output  CTRL_W  downstream control field, gated.
- o_level  output  2  occupancy, 0..2.
- i_cnt_clr  input  1  synchronous clear of the stall counter.
- o_stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- Storage:
  - Main register M (m_valid, m_data, m_ctrl) drives the outputs.
  - Skid register S (s_valid, s_data, s_ctrl) holds one extra payload.
- Asynchronous reset (i_reset_n=0) takes effect immediately:
  - m_valid = s_valid = 0; data fields = 0; ctrl fields = CTRL_RST; counter = 0.
  - Outputs: o_valid=0, o_in_ready=1, o_data=0, o_ctrl=CTRL_RST, o_level=0, o_stall_cnt=0.
- Combinational outputs:
  - o_in_ready = !s_valid. It depends only on registered state, never on i_out_ready.
  - o_valid = m_valid; o_data = m_data.
  - o_ctrl = m_valid ? m_ctrl : CTRL_RST, so there are no stale writes downstream.
  - o_level = m_valid + s_valid.
- Transfer conditions:
  - in_fire = i_valid & o_in_ready & i_clk_en.
  - out_fire = m_valid & i_out_ready & i_clk_en.
- Next-state rules (rising edge, i_clk_en=1, i_flush=0):
  - s_valid=1 and (out_fire or !m_valid): M <= S, s_valid <= 0.
  - s_valid=0 and (out_fire or !m_valid): M <= in_fire ? input : empty.
  - s_valid=0, m_valid=1, !out_fire, in_fire: S <= input; o_in_ready falls next cycle.
  - Otherwise: hold.
- Latency:
  - 1 cycle from in_fire to o_valid when the stage is empty.
  - Full throughput of 1 payload/cycle when i_out_ready is held high.
- Ordering: payloads leave strictly in arrival order. No payload is dropped or duplicated except by flush.
- i_clk_en=0:
  - All state holds; no transfer occurs even if valid and ready are high.
  - Outputs still reflect the held state.
- Flush (i_flush=1 at an edge):
  - Highest priority after reset; acts regardless of i_clk_en.
  - m_valid <= 0, s_valid <= 0, m_ctrl/s_ctrl <= CTRL_RST; data fields hold.
  - An input presented in the same cycle is discarded, and an output offered in that cycle is not counted as consumed.
- Stall counter:
  - Increments at each edge with i_clk_en & m_valid & !i_out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - i_cnt_clr=1 sets it to 0, taking priority over increment. Flush does not clear it.
- Reset mid-operation: all contents are discarded asynchronously. The first in_fire after reset release behaves as into an empty stage.

Test Plan:
- Reset then stream (i_out_ready=1, i_valid=1, data 1,2,3,4 on consecutive cycles) -> o_valid rises 1 cycle after first, o_data 1,2,3,4 back-to-back, o_level=1 throughout, o_in_ready=1 always.
- Back-pressure: stream A,B,C with i_out_ready=0 from cycle of B -> o_data holds A, B lands in S, o_level=2, o_in_ready=0, C held upstream; release ready -> A,B,C emerge in order, o_stall_cnt equals stalled cycles.
- Flush with level=2 and i_valid=1 -> next cycle o_valid=0, o_level=0, o_ctrl=CTRL_RST (e.g. 9'h000 while m_ctrl previously 9'h1FF), incoming payload absent afterwards.
- i_clk_en=0 for 3 cycles with i_valid=1, i_out_ready=1 -> no state change, o_level constant, counter unchanged; re-enable resumes exact sequence.
- Counter saturation with CNT_W=4: hold o_valid=1, i_out_ready=0 for 20 cycles -> o_stall_cnt=15; i_cnt_clr pulse -> 0 next edge.
- Async reset asserted mid-stream between edges -> outputs go to reset values immediately without a clock edge; after release the first payload appears 1 cycle after in_fire.
